// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
// Holds the fetch FSM states, the NOP word and the buffered entry layout.
package fetch_pkg;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned PC_W     = 64;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO holding fetched {pc, inst} entries.
// Head is valid whenever count is non-zero; clear empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching fetch stage: credit-limited requests to imem, in-order
// responses buffered for IF/ID, redirect flush with stale-response drain.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   deq_ready,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [XLEN-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] START_PC = RESET_PC & ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_nxt;
  logic [CW:0]     credit_sum;
  logic            grant;
  logic            rsp;
  logic            push;
  logic            pop;
  entry_t          din;
  entry_t          head;

  assign target_pc  = redirect_pc & ~XLEN'(3);
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};

  assign imem_req  = (state == FETCH) && !redirect && !reset &&
                     (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  // Responses with nothing outstanding are protocol errors and ignored.
  assign grant = imem_req && imem_gnt;
  assign rsp   = imem_rvalid && (outstanding != '0);
  assign push  = rsp && (state == FETCH) && !redirect;

  assign inst_valid = (count != '0);
  assign pop        = deq_ready && inst_valid && !redirect;
  assign din        = '{pc: resp_pc, inst: imem_rdata};
  assign out_nxt    = outstanding + CW'(grant) - CW'(rsp);

  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      redirect:
        state_nxt = (out_nxt != '0) ? DRAIN : FETCH;
      (state == DRAIN) && (out_nxt == '0):
        state_nxt = FETCH;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= START_PC;
      resp_pc     <= START_PC;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)  resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign inst    = inst_valid ? head.inst : NOP_INST;
  assign inst_pc = inst_valid ? head.pc : '0;

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue with a latency-programmable
// in-order memory model and directed redirect / reset scenarios.
module tb_instruction_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [2:0]  count;

  instruction_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_ready   (deq_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] a;
    int          due;
  } pend_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [63:0] hs_log[$];
  int          lat = 1;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          total = 0;
  int          passed = 0;

  function automatic logic [31:0] dat(input logic [63:0] a);
    return {a[15:0], 16'h5013};
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic expect_pc(input logic [63:0] a);
    exp_q.push_back('{pc: a, inst: dat(a)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_pop(input string n);
    int p;
    p = pop_cnt;
    for (int i = 0; i < 20 && pop_cnt == p; i++) tick();
    chk(n, 64'(pop_cnt - p), 64'd1);
  endtask

  // In-order memory: grant at cycle t answers at cycle t+lat.
  initial begin
    logic        hs;
    logic [63:0] ha;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = imem_req && imem_gnt;
      ha = imem_addr;
      if (reset) pend.delete();
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
        hs_log.push_back(ha);
        pend.push_back('{a: ha, due: cyc + lat - 1});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = dat(pend[0].a);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && inst_valid && deq_ready && !redirect) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", inst_pc, e.pc);
          chk("pop_inst", 64'(inst), 64'(e.inst));
        end
      end
    end
  end

  initial begin
    int p;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    deq_ready   = 1'b0;
    tick();
    tick();
    smp();
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_pc", inst_pc, 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // Fill with no consumer: four requests then credit stops.
    tick();
    reset    = 1'b0;
    imem_gnt = 1'b1;
    repeat (8) tick();
    smp();
    chk("fill_n", 64'(hs_log.size()), 64'd4);
    foreach (hs_log[i]) chk("fill_addr", hs_log[i], 64'(4 * i));
    chk("fill_req", 64'(imem_req), 64'd0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head_pc", inst_pc, 64'd0);
    chk("fill_head_inst", 64'(inst), 64'(dat(64'd0)));

    // Streaming: one pop per cycle for 12 cycles.
    for (int i = 0; i < 12; i++) expect_pc(64'(4 * i));
    p = pop_cnt;
    tick();
    deq_ready = 1'b1;
    repeat (12) tick();
    deq_ready = 1'b0;
    smp();
    chk("stream_pops", 64'(pop_cnt - p), 64'd12);
    repeat (6) tick();

    // Redirect with nothing outstanding, then redirect into DRAIN.
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    lat         = 3;
    tick();
    redirect = 1'b0;
    smp();
    chk("rd0_valid", 64'(inst_valid), 64'd0);
    chk("rd0_count", 64'(count), 64'd0);
    chk("rd0_req", 64'(imem_req), 64'd1);
    chk("rd0_addr", imem_addr, 64'h40);
    tick();
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    tick();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    smp();
    chk("drain_req0", 64'(imem_req), 64'd0);
    tick();
    smp();
    chk("drain_req1", 64'(imem_req), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    tick();
    smp();
    chk("post_drain_req", 64'(imem_req), 64'd1);
    chk("post_drain_addr", imem_addr, 64'h100);
    tick();
    imem_gnt = 1'b0;
    expect_pc(64'h100);
    deq_ready = 1'b1;
    wait_pop("pop_100");
    deq_ready = 1'b0;

    // Grant held off: address and request must hold.
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("hold_req", 64'(imem_req), 64'd1);
      chk("hold_addr", imem_addr, 64'h8);
      if (i < 2) tick();
    end
    tick();
    imem_gnt = 1'b1;
    tick();
    smp();
    chk("after_gnt_addr", imem_addr, 64'hC);
    tick();
    tick();
    imem_gnt = 1'b0;
    tick();
    tick();

    // Redirect + rvalid + deq_ready together with two entries buffered.
    smp();
    chk("pre_rd_count", 64'(count), 64'd2);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    deq_ready   = 1'b1;
    p = pop_cnt;
    tick();
    redirect  = 1'b0;
    deq_ready = 1'b0;
    smp();
    chk("rd_count", 64'(count), 64'd0);
    chk("rd_valid", 64'(inst_valid), 64'd0);
    chk("rd_nopop", 64'(pop_cnt - p), 64'd0);
    chk("rd_req", 64'(imem_req), 64'd1);
    chk("rd_addr", imem_addr, 64'h200);
    lat = 1;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    expect_pc(64'h200);
    deq_ready = 1'b1;
    wait_pop("pop_200");
    deq_ready = 1'b0;

    // Reset while draining two stale responses.
    lat = 5;
    tick();
    imem_gnt = 1'b1;
    tick();
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h300;
    tick();
    redirect = 1'b0;
    smp();
    chk("drain2_req", 64'(imem_req), 64'd0);
    tick();
    reset = 1'b1;
    smp();
    chk("in_rst_req", 64'(imem_req), 64'd0);
    tick();
    reset = 1'b0;
    smp();
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_valid", 64'(inst_valid), 64'd0);
    chk("post_rst_inst", 64'(inst), 64'h13);
    chk("post_rst_req", 64'(imem_req), 64'd1);
    chk("post_rst_addr", imem_addr, 64'd0);
    lat = 1;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    expect_pc(64'd0);
    deq_ready = 1'b1;
    wait_pop("pop_rst");
    deq_ready = 1'b0;
    tick();

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
